// File: rtl/mem_pkg.sv
// Shared memory-hierarchy definitions: word width, RAM8 address width, word type.
package mem_pkg;
  localparam int WORD_W      = 16;
  localparam int RAM8_ADDR_W = 3;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/register_16.sv
// WIDTH-bit storage register with load enable and async active-high clear.
module register_16
  import mem_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Clear wins over load; otherwise capture in when load is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     out <= '0;
    else if (load) out <= in;
  end

endmodule

// File: rtl/ram_8.sv
// 8 x WIDTH RAM: synchronous write, combinational read of word[address].
// Built from one register per word, a load demux and an output mux.
module ram_8
  import mem_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = RAM8_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]            ld;
  logic [DEPTH-1:0][WIDTH-1:0] q;

  // Load demux: only the addressed word sees load; decode covers every address.
  always_comb begin
    ld          = '0;
    ld[address] = load;
  end

  genvar w;
  generate
    for (w = 0; w < DEPTH; w++) begin : g_word
      register_16 #(.WIDTH(WIDTH)) u_reg (
        .clk  (clk),
        .reset(reset),
        .load (ld[w]),
        .in   (in),
        .out  (q[w])
      );
    end
  endgenerate

  // Read mux: no bypass from in, so a same-cycle write shows up after the edge.
  assign out = q[address];

endmodule

// File: tb/tb_ram_8.sv
// Directed self-checking bench for ram_8.
module tb_ram_8;

  logic        clk;
  logic        reset;
  logic        load;
  logic [2:0]  address;
  logic [15:0] in;
  logic [15:0] out;

  int n_chk  = 0;
  int n_pass = 0;

  ram_8 dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .address(address),
    .in     (in),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // Single write: drive at negedge, commit on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    #1;
    chk(tag, out, exp);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    address = '0;
    in      = '0;

    // Reset: sweep all addresses while reset is held, then after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_hold_%0d", i), 3'(i), 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_rel_%0d", i), 3'(i), 16'h0000);

    // Sequential writes then reads.
    wr(3'd0, 16'h1111);
    wr(3'd1, 16'h2222);
    wr(3'd2, 16'h3333);
    @(negedge clk);
    rd("seq_0", 3'd0, 16'h1111);
    rd("seq_1", 3'd1, 16'h2222);
    rd("seq_2", 3'd2, 16'h3333);
    for (int i = 3; i < 8; i++) rd($sformatf("seq_empty_%0d", i), 3'(i), 16'h0000);

    // Overwrite one word, neighbours untouched.
    wr(3'd1, 16'hAAAA);
    @(negedge clk);
    rd("ovw_1", 3'd1, 16'hAAAA);
    rd("ovw_0", 3'd0, 16'h1111);
    rd("ovw_2", 3'd2, 16'h3333);

    // load=0 isolation across several edges.
    @(negedge clk);
    address = 3'd4;
    in      = 16'hFFFF;
    load    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd("iso_4", 3'd4, 16'h0000);
    rd("iso_0", 3'd0, 16'h1111);
    rd("iso_1", 3'd1, 16'hAAAA);
    rd("iso_2", 3'd2, 16'h3333);
    rd("iso_7", 3'd7, 16'h0000);

    // Same-cycle write/read: old value before the edge, new value after.
    @(negedge clk);
    address = 3'd5;
    in      = 16'h5A5A;
    load    = 1'b1;
    #1;
    chk("same_pre", out, 16'h0000);
    @(posedge clk);
    #1;
    chk("same_post", out, 16'h5A5A);
    load = 1'b0;

    // Fill all words with 0x0101*index, verify, then async reset between edges.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h0101 * i));
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd($sformatf("fill_%0d", i), 3'(i), 16'(16'h0101 * i));
    address = 3'd7;
    #2;
    reset = 1'b1;
    #1;
    chk("async_clr", out, 16'h0000);
    for (int i = 0; i < 8; i++) rd($sformatf("async_hold_%0d", i), 3'(i), 16'h0000);
    // A write attempted while reset is held must not land.
    load    = 1'b1;
    address = 3'd3;
    in      = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("rst_prio", out, 16'h0000);
    @(negedge clk);
    load  = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rd($sformatf("post_rst_%0d", i), 3'(i), 16'h0000);

    // First edge after release accepts a write.
    wr(3'd6, 16'hC0DE);
    @(negedge clk);
    rd("first_wr_6", 3'd6, 16'hC0DE);
    rd("first_wr_5", 3'd5, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
